// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: byte-addressable data memory for loads/stores with a registered one-cycle response
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready handshake with req_we, req_addr,
//        req_size, req_unsigned, req_wdata; rsp_valid pulse with rsp_rdata/rsp_err; init_done.
// Option: define DATA_RAM_INIT_CLEAR_EN to zero every word in an INIT sweep after reset.
module data_ram_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic {INIT, RUN} state_e;
    state_e                state_q, state_d;
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] off, word_off;
    logic [IW-1:0]         idx;
    logic [1:0]            lane;
    logic                  err, acc;
    logic [3:0]            be;
    logic [31:0]           wdata_sh, word_sh, load_d;
    logic                  rsp_valid_q, rsp_err_q;
    logic [31:0]           rsp_rdata_q;
    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign off      = req_addr - BASE_ADDR;
    assign word_off = off >> 2;
    assign idx      = word_off[IW-1:0];
    assign lane     = off[1:0];
    assign err      = (req_size == 2'b11) || (req_size == 2'b01 && lane[0]) ||
                      (req_size == 2'b10 && lane != 2'b00) || (word_off >= ADDR_WIDTH'(DEPTH));
    assign acc      = req_valid && req_ready && rst_n;
    assign be       = req_size == 2'b00 ? 4'b0001 << lane : req_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
    assign wdata_sh = req_wdata << {lane, 3'b000};
    assign word_sh  = mem[idx] >> {lane, 3'b000};
    assign load_d   = (req_we || err) ? 32'h0 :
                      req_size == 2'b00 ? {{24{~req_unsigned & word_sh[7]}}, word_sh[7:0]} :
                      req_size == 2'b01 ? {{16{~req_unsigned & word_sh[15]}}, word_sh[15:0]} : word_sh;
`ifdef DATA_RAM_INIT_CLEAR_EN
    logic [IW-1:0] clr_q, clr_d;
    assign clr_d = state_q == INIT ? clr_q + IW'(1) : clr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) clr_q <= '0;
        else        clr_q <= clr_d;
    end
    // Leave INIT on the edge that clears the last word.
    always_comb state_d = (state_q == INIT && clr_q != IW'(DEPTH - 1)) ? INIT : RUN;
`else
    always_comb state_d = RUN;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end
    always_comb begin
        req_ready = state_q == RUN;
        init_done = state_q == RUN;
    end
    always_ff @(posedge clk) begin
`ifdef DATA_RAM_INIT_CLEAR_EN
        if (state_q == INIT) mem[clr_q] <= '0;
`endif
        if (acc && req_we && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= acc;
            if (acc) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= load_d;
            end
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed self-checking bench for data_ram_ctrl at DEPTH=16
module tb_data_ram_ctrl;
    logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        @(posedge clk); #1;
        check({tag, " valid"}, rsp_valid, 1);
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, rsp_err, exp_err);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic release_and_wait(input string tag);
        @(negedge clk);
        rst_n = 1;
`ifdef DATA_RAM_INIT_CLEAR_EN
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check({tag, " ready low"}, req_ready, 0);
            check({tag, " done low"}, init_done, 0);
        end
`endif
        @(posedge clk); #1;
        check({tag, " ready"}, req_ready, 1);
        check({tag, " done"}, init_done, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", req_ready, 0);
        check("rst valid", rsp_valid, 0);
        check("rst rdata", rsp_rdata, 0);
        check("rst err", rsp_err, 0);
        check("rst done", init_done, 0);
        release_and_wait("init1");
`ifdef DATA_RAM_INIT_CLEAR_EN
        for (int w = 0; w < 16; w++) xfer("clr lw", 0, 32'(w * 4), 2'b10, 0, 0, 32'h0, 0);
`endif
        xfer("sw 8", 1, 32'h8, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
        xfer("sb 9", 1, 32'h9, 2'b00, 0, 32'h00000055, 32'h0, 0);
        xfer("lw 8", 0, 32'h8, 2'b10, 0, 0, 32'hDEAD55EF, 0);
        xfer("lb b", 0, 32'hB, 2'b00, 0, 0, 32'hFFFFFFDE, 0);
        xfer("lbu b", 0, 32'hB, 2'b00, 1, 0, 32'h000000DE, 0);
        idle();
        @(posedge clk); #1;
        check("idle valid", rsp_valid, 0);
        check("idle hold", rsp_rdata, 32'h000000DE);
        xfer("lh a", 0, 32'hA, 2'b01, 0, 0, 32'hFFFFDEAD, 0);
        xfer("lbu 9", 0, 32'h9, 2'b00, 1, 0, 32'h00000055, 0);
        xfer("sw 4", 1, 32'h4, 2'b10, 0, 32'h0, 32'h0, 0);
        xfer("sh 6", 1, 32'h6, 2'b01, 0, 32'h00008001, 32'h0, 0);
        xfer("lh 6", 0, 32'h6, 2'b01, 0, 0, 32'hFFFF8001, 0);
        xfer("lhu 6", 0, 32'h6, 2'b01, 1, 0, 32'h00008001, 0);
        xfer("lw 4", 0, 32'h4, 2'b10, 0, 0, 32'h80010000, 0);
        xfer("sw 0", 1, 32'h0, 2'b10, 0, 32'h12345678, 32'h0, 0);
        xfer("lw 2 err", 0, 32'h2, 2'b10, 0, 0, 32'h0, 1);
        xfer("sh 3 err", 1, 32'h3, 2'b01, 0, 32'hFFFF, 32'h0, 1);
        xfer("sz11 err", 1, 32'h0, 2'b11, 0, 32'hFFFFFFFF, 32'h0, 1);
        xfer("lw 40 err", 0, 32'h40, 2'b10, 0, 0, 32'h0, 1);
        xfer("sw 40 err", 1, 32'h40, 2'b10, 0, 32'hAAAAAAAA, 32'h0, 1);
        xfer("lw 0 kept", 0, 32'h0, 2'b10, 0, 0, 32'h12345678, 0);
        xfer("lw 8 pre", 0, 32'h8, 2'b10, 0, 0, 32'hDEAD55EF, 0);
        @(negedge clk);
        req_valid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        check("midrst valid", rsp_valid, 0);
        check("midrst rdata", rsp_rdata, 0);
        check("midrst ready", req_ready, 0);
        release_and_wait("init2");
`ifdef DATA_RAM_INIT_CLEAR_EN
        xfer("lw 8 clr", 0, 32'h8, 2'b10, 0, 0, 32'h0, 0);
        xfer("lw 0 clr", 0, 32'h0, 2'b10, 0, 0, 32'h0, 0);
`else
        xfer("sw 0 b", 1, 32'h0, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0);
        xfer("lw 0 b", 0, 32'h0, 2'b10, 0, 0, 32'hCAFEF00D, 0);
`endif
        idle();
        @(posedge clk); #1;
        check("end valid", rsp_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
